// File: rtl/stack_pkg.sv
// Shared constants and op decode for the operand stack (stack_unit).
package stack_pkg;

  localparam int unsigned STACK_WIDTH = 8;
  localparam int unsigned STACK_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b10,
    OP_POP     = 2'b01,
    OP_REPLACE = 2'b11
  } stack_op_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Address width of the below-TOS array (DEPTH-1 words), never less than 1.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth - 1 > 1) ? $clog2(depth - 1) : 1;
  endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Controller-to-stack bundle: push/pop strobes, data in, TOS and status out.
interface stack_unit_if
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = STACK_WIDTH,
  parameter int unsigned DEPTH = STACK_DEPTH
);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             err_clr;
  logic [WIDTH-1:0] tos;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, din, err_clr,
    input  tos, empty, full, count, overflow, underflow
  );

  modport slave (
    input  push, pop, din, err_clr,
    output tos, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/stack_ram.sv
// Below-TOS storage: synchronous write, asynchronous read, no reset.
module stack_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORDS = 7,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/stack_unit.sv
// Operand stack with registered TOS cache over a small array.
// Define STACK_ERR_STICKY_EN to make overflow/underflow sticky until err_clr.
module stack_unit
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = STACK_WIDTH,
  parameter int unsigned DEPTH = STACK_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  stack_unit_if.slave bus
);
  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned AW    = addr_width(DEPTH);

  stack_op_e        op;
  logic [WIDTH-1:0] tos_r;
  logic [CNT_W-1:0] count_r;
  logic             ovf_r;
  logic             unf_r;
  logic             full_w;
  logic             empty_w;
  logic             ovf_evt;
  logic             unf_evt;
  logic             ram_we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;

  assign op      = stack_op_e'({bus.push, bus.pop});
  assign full_w  = (count_r == CNT_W'(DEPTH));
  assign empty_w = (count_r == '0);
  assign ovf_evt = (op == OP_PUSH) && full_w;
  assign unf_evt = ((op == OP_POP) || (op == OP_REPLACE)) && empty_w;

  // Old TOS spills to array[count-1]; the entry below TOS sits at count-2.
  assign ram_we = (op == OP_PUSH) && !full_w && !empty_w;
  assign waddr  = AW'(count_r - CNT_W'(1));
  assign raddr  = AW'(count_r - CNT_W'(2));

  stack_ram #(
    .WIDTH (WIDTH),
    .WORDS (DEPTH - 1),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (waddr),
    .wdata (tos_r),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tos_r   <= '0;
      count_r <= '0;
    end else begin
      case (op)
        OP_PUSH: if (!full_w) begin
          tos_r   <= bus.din;
          count_r <= count_r + CNT_W'(1);
        end
        OP_POP: if (!empty_w) begin
          tos_r   <= (count_r >= CNT_W'(2)) ? rdata : '0;
          count_r <= count_r - CNT_W'(1);
        end
        OP_REPLACE: if (!empty_w) tos_r <= bus.din;
        default: ;
      endcase
    end
  end

`ifdef STACK_ERR_STICKY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_evt | (ovf_r & ~bus.err_clr);
      unf_r <= unf_evt | (unf_r & ~bus.err_clr);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_evt;
      unf_r <= unf_evt;
    end
  end
`endif

  assign bus.tos       = tos_r;
  assign bus.count     = count_r;
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.overflow  = ovf_r;
  assign bus.underflow = unf_r;
endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit (default and STACK_ERR_STICKY_EN builds).
module tb_stack_unit;
  import stack_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned D = 8;
`ifdef STACK_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  stack_unit_if #(.WIDTH(W), .DEPTH(D)) bus ();

  stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Apply one op for one clock, sample 1 time unit after the edge.
  task automatic do_op(input logic p, input logic q, input logic [W-1:0] d, input logic clr);
    bus.push    = p;
    bus.pop     = q;
    bus.din     = d;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [W-1:0] t, input int unsigned c);
    check({tag, ".tos"},   32'(bus.tos),   32'(t));
    check({tag, ".count"}, 32'(bus.count), 32'(c));
    check({tag, ".empty"}, 32'(bus.empty), 32'(c == 0));
    check({tag, ".full"},  32'(bus.full),  32'(c == D));
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.din = '0; bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 8'h00, 0);
    check("reset.ovf", 32'(bus.overflow), 0);
    check("reset.unf", 32'(bus.underflow), 0);
    rst = 1'b1;
    do_op(0, 0, 8'hFF, 0);
    check_state("idle", 8'h00, 0);

    // Basic LIFO
    do_op(1, 0, 8'h11, 0); check_state("push11", 8'h11, 1);
    do_op(1, 0, 8'h22, 0); check_state("push22", 8'h22, 2);
    do_op(1, 0, 8'h33, 0); check_state("push33", 8'h33, 3);
    do_op(0, 1, 8'h00, 0); check_state("pop1", 8'h22, 2);
    do_op(0, 1, 8'h00, 0); check_state("pop2", 8'h11, 1);
    do_op(0, 1, 8'h00, 0); check_state("pop3", 8'h00, 0);

    // Fill, overflow, drain
    for (int i = 1; i <= 8; i++) do_op(1, 0, 8'(i), 0);
    check_state("fill", 8'h08, 8);
    do_op(1, 0, 8'h99, 0);
    check_state("ovf_push", 8'h08, 8);
    check("ovf_set", 32'(bus.overflow), 1);
    do_op(0, 0, 8'h00, 0);
    check("ovf_after_idle", 32'(bus.overflow), 32'(STICKY));
    do_op(0, 0, 8'h00, 1);
    check("ovf_clr", 32'(bus.overflow), 0);
    for (int i = 7; i >= 0; i--) begin
      do_op(0, 1, 8'h00, 0);
      check_state($sformatf("drain%0d", i), 8'(i), i);
    end

    // Underflow on empty
    do_op(0, 1, 8'h00, 0);
    check_state("unf_pop", 8'h00, 0);
    check("unf_set", 32'(bus.underflow), 1);
    do_op(0, 0, 8'h00, 0);
    check("unf_after_idle", 32'(bus.underflow), 32'(STICKY));
    do_op(0, 0, 8'h00, 1);
    check("unf_clr", 32'(bus.underflow), 0);
    do_op(1, 1, 8'h77, 0);
    check_state("unf_repl", 8'h00, 0);
    check("unf_repl_flag", 32'(bus.underflow), 1);
    do_op(0, 1, 8'h00, 1);
    check("unf_err_wins", 32'(bus.underflow), 1);
    do_op(0, 0, 8'h00, 1);
    check("unf_clr2", 32'(bus.underflow), 0);

    // Replace with one entry
    do_op(1, 0, 8'h44, 0);
    do_op(1, 1, 8'h55, 0);
    check_state("repl1", 8'h55, 1);
    check("repl1.unf", 32'(bus.underflow), 0);
    do_op(0, 1, 8'h00, 0);
    check_state("repl1_pop", 8'h00, 0);

    // Replace when full: no overflow, below-TOS entries untouched
    for (int i = 1; i <= 8; i++) do_op(1, 0, 8'(i), 0);
    do_op(1, 1, 8'hAA, 0);
    check_state("repl_full", 8'hAA, 8);
    check("repl_full.ovf", 32'(bus.overflow), 0);
    do_op(0, 1, 8'h00, 0);
    check_state("repl_full_pop", 8'h07, 7);

    // Asynchronous reset between edges
    do_op(1, 0, 8'h21, 0);
    do_op(1, 0, 8'h22, 0);
    do_op(1, 0, 8'h23, 0);
    #2;
    rst = 1'b0;
    #1;
    check_state("async_rst", 8'h00, 0);
    check("async_rst.ovf", 32'(bus.overflow), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_op(1, 0, 8'h5A, 0);
    check_state("post_rst", 8'h5A, 1);
    do_op(0, 1, 8'h00, 0);
    check_state("post_rst_pop", 8'h00, 0);

`ifdef STACK_ERR_STICKY_EN
    do_op(0, 1, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      do_op(0, 0, 8'h00, 0);
      check($sformatf("sticky_hold%0d", i), 32'(bus.underflow), 1);
    end
    do_op(0, 0, 8'h00, 1);
    check("sticky_clr", 32'(bus.underflow), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
